// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, MDU latency default
// and counter widths.
package pipeline_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hazard_state_t;

  localparam int MDU_LATENCY_DEFAULT = 4;
  localparam int MDU_CNT_W           = 4;
  localparam int STAT_CNT_W          = 16;

endpackage : pipeline_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter
  import pipeline_pkg::*;
#(
  parameter int WIDTH = STAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: dmem stall, multi-cycle MDU hold, branch flush, load-use stall.
// Optional statistics counters enabled by defining HAZARD_STATS_EN.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_memread,
  input  logic [4:0]            id_ex_registerrt,
  input  logic [4:0]            if_id_registerrs,
  input  logic [4:0]            if_id_registerrt,
  input  logic                  id_ex_mdu_start,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  ex_mem_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic [STAT_CNT_W-1:0] stall_cnt,
  output logic [STAT_CNT_W-1:0] flush_cnt
);

  hazard_state_t          state_q, state_d;
  logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic                   load_use;

  assign load_use = id_ex_memread && (id_ex_registerrt != 5'd0) &&
                    ((id_ex_registerrt == if_id_registerrs) ||
                     (id_ex_registerrt == if_id_registerrt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // NOTE: every output and next-state signal gets a default first so no path
  // through the priority chain leaves a latch behind.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    mdu_cnt_d    = mdu_cnt_q;

    // Reset gates the outputs so an aborted MDU hold never leaks out.
    if (!rst_n) begin
      state_d = RUN;
    end else if (dmem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state_q == MDU_WAIT) begin
      if (mdu_cnt_q != '0) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        mdu_cnt_d    = mdu_cnt_q - MDU_CNT_W'(1);
      end else begin
        // Release cycle: defaults only, a new MDU start is not accepted here.
        state_d = RUN;
      end
    end else if (id_ex_mdu_start) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_flush = 1'b1;
      mdu_cnt_d    = MDU_CNT_W'(MDU_LATENCY - 1);
      state_d      = MDU_WAIT;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  sat_counter #(.WIDTH(STAT_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(STAT_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_id_flush),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MDU_LATENCY = 4).
module tb_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_ex_memread;
  logic [4:0]  id_ex_registerrt;
  logic [4:0]  if_id_registerrs;
  logic [4:0]  if_id_registerrt;
  logic        id_ex_mdu_start;
  logic        branch_taken;
  logic        dmem_busy;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic [7:0]  ctl;

  int asserts = 0;
  int fails   = 0;

  // {pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}
  localparam logic [7:0] DEF  = 8'b1111_0000;
  localparam logic [7:0] HOLD = 8'b0001_0010;
  localparam logic [7:0] BUSY = 8'b0000_0001;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] LU   = 8'b0011_0100;

  assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  hazard_unit #(.MDU_LATENCY(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_ex_memread    (id_ex_memread),
    .id_ex_registerrt (id_ex_registerrt),
    .if_id_registerrs (if_id_registerrs),
    .if_id_registerrt (if_id_registerrt),
    .id_ex_mdu_start  (id_ex_mdu_start),
    .branch_taken     (branch_taken),
    .dmem_busy        (dmem_busy),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .id_ex_write      (id_ex_write),
    .ex_mem_write     (ex_mem_write),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .mem_wb_flush     (mem_wb_flush),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    id_ex_memread    = 1'b0;
    id_ex_registerrt = 5'd0;
    if_id_registerrs = 5'd0;
    if_id_registerrt = 5'd0;
    id_ex_mdu_start  = 1'b0;
    branch_taken     = 1'b0;
    dmem_busy        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    asserts++;
    if (ctl !== DEF) begin fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl, DEF); end
    asserts++;
    if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
    asserts++;
    if (flush_cnt !== 16'd0) begin fails++; $display("FAIL reset_flush_cnt got=%h exp=0", flush_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    asserts++;
    if (ctl !== DEF) begin fails++; $display("FAIL idle_ctl got=%b exp=%b", ctl, DEF); end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    // {memread, ex_rt, id_rs, id_rt, expected}
    logic        mr  [5] = '{1'b1, 1'b1,  1'b1,  1'b1,  1'b0};
    logic [4:0]  ert [5] = '{5'd5, 5'd5,  5'd0,  5'd5,  5'd5};
    logic [4:0]  irs [5] = '{5'd5, 5'd3,  5'd0,  5'd6,  5'd5};
    logic [4:0]  irt [5] = '{5'd1, 5'd5,  5'd0,  5'd7,  5'd5};
    logic [7:0]  exp [5] = '{LU,   LU,    DEF,   DEF,   DEF};
    for (int i = 0; i < 5; i++) begin
      id_ex_memread    = mr[i];
      id_ex_registerrt = ert[i];
      if_id_registerrs = irs[i];
      if_id_registerrt = irt[i];
      #1;
      asserts++;
      if (ctl !== exp[i]) begin fails++; $display("FAIL load_use[%0d] got=%b exp=%b", i, ctl, exp[i]); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_mdu();
    // Start held through the release cycle, then a fresh op from RUN.
    logic [7:0] exp [11] = '{HOLD, HOLD, HOLD, HOLD, DEF, HOLD,
                             HOLD, HOLD, HOLD, DEF, DEF};
    for (int i = 0; i < 11; i++) begin
      id_ex_mdu_start = (i <= 5);
      #1;
      asserts++;
      if (ctl !== exp[i]) begin fails++; $display("FAIL mdu[%0d] got=%b exp=%b", i, ctl, exp[i]); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    #1;
    asserts++;
    if (ctl !== BR) begin fails++; $display("FAIL branch got=%b exp=%b", ctl, BR); end
    id_ex_memread    = 1'b1;
    id_ex_registerrt = 5'd9;
    if_id_registerrs = 5'd9;
    #1;
    asserts++;
    if (ctl !== BR) begin fails++; $display("FAIL branch_over_load_use got=%b exp=%b", ctl, BR); end
    @(negedge clk);
    idle_inputs();
    branch_taken = 1'b1;
    dmem_busy    = 1'b1;
    #1;
    asserts++;
    if (ctl !== BUSY) begin fails++; $display("FAIL branch_during_busy got=%b exp=%b", ctl, BUSY); end
    @(negedge clk);
    dmem_busy = 1'b0;
    #1;
    asserts++;
    if (ctl !== BR) begin fails++; $display("FAIL branch_after_busy got=%b exp=%b", ctl, BR); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mdu_busy();
    logic [7:0] exp [8] = '{HOLD, HOLD, BUSY, BUSY, BUSY, HOLD, HOLD, DEF};
    int holds = 0;
    for (int i = 0; i < 8; i++) begin
      id_ex_mdu_start = (i == 0);
      dmem_busy       = (i >= 2) && (i <= 4);
      #1;
      if (!pc_write) holds++;
      asserts++;
      if (ctl !== exp[i]) begin fails++; $display("FAIL mdu_busy[%0d] got=%b exp=%b", i, ctl, exp[i]); end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    asserts++;
    if (ctl !== DEF) begin fails++; $display("FAIL mdu_busy_run got=%b exp=%b", ctl, DEF); end
    asserts++;
    if (holds !== 7) begin fails++; $display("FAIL mdu_busy_holds got=%0d exp=7", holds); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mdu();
    id_ex_mdu_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // Now in MDU_WAIT with two hold cycles left; keep start high through reset.
    #1;
    rst_n = 1'b0;
    #1;
    asserts++;
    if (ctl !== DEF) begin fails++; $display("FAIL rst_mid_ctl got=%b exp=%b", ctl, DEF); end
    asserts++;
    if (stall_cnt !== 16'd0) begin fails++; $display("FAIL rst_mid_stall got=%h exp=0", stall_cnt); end
    asserts++;
    if (flush_cnt !== 16'd0) begin fails++; $display("FAIL rst_mid_flush got=%h exp=0", flush_cnt); end
    @(negedge clk);
    rst_n           = 1'b1;
    id_ex_mdu_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      asserts++;
      if (ctl !== DEF) begin fails++; $display("FAIL rst_mid_after[%0d] got=%b exp=%b", i, ctl, DEF); end
      @(negedge clk);
    end
  endtask

  task automatic test_stats();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n     = 1'b1;
    dmem_busy = 1'b1;
    for (int i = 0; i < 65534; i++) @(negedge clk);
    #1;
`ifdef HAZARD_STATS_EN
    asserts++;
    if (stall_cnt !== 16'hFFFE) begin fails++; $display("FAIL stats_preload got=%h exp=fffe", stall_cnt); end
`else
    asserts++;
    if (stall_cnt !== 16'h0000) begin fails++; $display("FAIL stats_tied_stall got=%h exp=0", stall_cnt); end
`endif
    for (int i = 0; i < 3; i++) @(negedge clk);
    dmem_busy    = 1'b0;
    branch_taken = 1'b1;
    #1;
`ifdef HAZARD_STATS_EN
    asserts++;
    if (stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL stats_saturate got=%h exp=ffff", stall_cnt); end
`else
    asserts++;
    if (stall_cnt !== 16'h0000) begin fails++; $display("FAIL stats_tied_stall2 got=%h exp=0", stall_cnt); end
`endif
    @(negedge clk);
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
`ifdef HAZARD_STATS_EN
    asserts++;
    if (flush_cnt !== 16'd2) begin fails++; $display("FAIL stats_flush got=%h exp=2", flush_cnt); end
`else
    asserts++;
    if (flush_cnt !== 16'd0) begin fails++; $display("FAIL stats_tied_flush got=%h exp=0", flush_cnt); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_branch();
    test_mdu_busy();
    test_reset_mid_mdu();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule : tb_hazard_unit
